// File: rtl/display_pkg.sv
// Shared types and glyph table for the millivolt display path.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package display_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    function automatic logic [6:0] seg_decode(input bcd_digit_t d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/mv_display_driver_if.sv
// Handshake bundle between the change detector and the
// sequential binary-to-BCD converter.
interface mv_display_driver_if;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [19:0] bcd;

    modport master (output start, bin, input busy, done, bcd);
    modport slave  (input start, bin, output busy, done, bcd);
endinterface

// File: rtl/mv_display_driver_bin2bcd_seq.sv
// Sequential double-dabble: 16 shift cycles plus one DONE cycle.
// busy and done are registered alongside the state.
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    mv_display_driver_if.slave   conv
);

    conv_state_t state;
    logic [15:0] sh;
    logic [19:0] acc;
    logic [3:0]  cnt;
    logic        busy_q;
    logic        done_q;

    function automatic logic [19:0] add3(input logic [19:0] a);
        logic [19:0] r;
        r = a;
        for (int i = 0; i < 5; i++) begin
            if (a[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    logic [35:0] step;
    assign step = {add3(acc), sh};

    // Converter FSM: capture, shift 16 times, then flag completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            sh     <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (conv.start) begin
                        sh     <= conv.bin;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {acc, sh} <= {step[34:0], 1'b0};
                    cnt       <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign conv.bcd  = acc;
    assign conv.busy = busy_q;
    assign conv.done = done_q;

endmodule

// File: rtl/mv_display_driver.sv
// Millivolt to 4-digit multiplexed seven-segment driver.
// Digits are latched only on converter completion, so no tearing.
module mv_display_driver
    import display_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int DIGIT_HZ      = 1000,
    parameter int DP_DIGIT      = 3,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [15:0] bcd,
    output logic        overflow,
    output logic        busy
);

    localparam int DIV = CLK_HZ / DIGIT_HZ;
    localparam logic [31:0] DIV_LAST = 32'(DIV - 1);
    // With no decimal point, blanking may reach down to the tens digit.
    localparam int BLANK_FLOOR = (DP_DIGIT > 3) ? 0 : DP_DIGIT;

    mv_display_driver_if conv ();

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .conv  (conv)
    );

    logic [15:0] last_cap;
    logic [31:0] presc;
    logic [1:0]  idx;

    assign conv.start = !conv.busy && (value != last_cap);
    assign conv.bin   = value;
    assign busy       = conv.busy;

    // Change detector and atomic digit latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_cap <= '0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            if (conv.start)
                last_cap <= value;
            if (conv.done) begin
                bcd      <= conv.bcd[15:0];
                overflow <= |conv.bcd[19:16];
            end
        end
    end

    // Dwell prescaler stepping the digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == DIV_LAST) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + 32'd1;
        end
    end

    bcd_digit_t dig;
    logic [3:0] zero;
    logic       upper_zero;
    logic       blank;
    logic [6:0] seg_nxt;
    logic       dp_nxt;

    // Digit rendering: overflow dash, leading-zero blank, glyph.
    always_comb begin
        dig = bcd[{idx, 2'b00} +: 4];
        zero = '0;
        for (int i = 0; i < 4; i++)
            zero[i] = (bcd[i*4 +: 4] == 4'd0);
        case (idx)
            2'd3:    upper_zero = zero[3];
            2'd2:    upper_zero = &zero[3:2];
            2'd1:    upper_zero = &zero[3:1];
            default: upper_zero = 1'b0;
        endcase
        blank = (BLANK_LEADING != 0) && (int'(idx) > BLANK_FLOOR)
                && upper_zero;
        if (overflow)
            seg_nxt = SEG_DASH;
        else if (blank)
            seg_nxt = SEG_BLANK;
        else
            seg_nxt = seg_decode(dig);
        dp_nxt = !((int'(idx) == DP_DIGIT) && !overflow);
    end

    // Register anode, segments and point together from one index.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'hF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_mv_display_driver.sv
// Directed bench for mv_display_driver with DIV=4.
// Instance a uses the default point/blanking; b has no point.
module tb_mv_display_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value_a, value_b;
    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [15:0] bcd_a, bcd_b;
    logic        ovf_a, ovf_b;
    logic        busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mv_display_driver #(
        .CLK_HZ(4), .DIGIT_HZ(1), .DP_DIGIT(3), .BLANK_LEADING(1)
    ) dut_a (
        .clk(clk), .reset(reset), .value(value_a),
        .an(an_a), .seg(seg_a), .dp(dp_a),
        .bcd(bcd_a), .overflow(ovf_a), .busy(busy_a)
    );

    mv_display_driver #(
        .CLK_HZ(4), .DIGIT_HZ(1), .DP_DIGIT(4), .BLANK_LEADING(1)
    ) dut_b (
        .clk(clk), .reset(reset), .value(value_b),
        .an(an_b), .seg(seg_b), .dp(dp_b),
        .bcd(bcd_b), .overflow(ovf_b), .busy(busy_b)
    );

    typedef struct {
        logic [15:0]      value;
        logic [15:0]      bcd;
        logic             ovf;
        logic [3:0][6:0]  seg;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_digit(input bit b, input int i,
                               input logic [6:0] exp_seg,
                               input logic exp_dp);
        logic [3:0] want;
        bit found;
        want = ~(4'b0001 << i);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (!b && an_a == want) begin
                found = 1;
                check($sformatf("a_seg%0d", i), 32'(seg_a), 32'(exp_seg));
                check($sformatf("a_dp%0d", i), 32'(dp_a), 32'(exp_dp));
            end else if (b && an_b == want) begin
                found = 1;
                check($sformatf("b_seg%0d", i), 32'(seg_b), 32'(exp_seg));
                check($sformatf("b_dp%0d", i), 32'(dp_b), 32'(exp_dp));
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL scan_timeout digit=%0d got=none exp=seen", i);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_an", 32'(an_a), 32'hF);
        check("rst_seg", 32'(seg_a), 32'h7F);
        check("rst_dp", 32'(dp_a), 32'h1);
        check("rst_bcd", 32'(bcd_a), 32'h0);
        check("rst_ovf", 32'(ovf_a), 32'h0);
        check("rst_busy", 32'(busy_a), 32'h0);
    endtask

    vec_t tbl [8];

    initial begin
        logic [3:0] seq [8];
        logic [3:0] last;
        int n;

        tbl[0] = '{16'd12345, 16'h2345, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
        tbl[1] = '{16'd9999,  16'h9999, 1'b0, {7'h10, 7'h10, 7'h10, 7'h10}};
        tbl[2] = '{16'd10000, 16'h0000, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
        tbl[3] = '{16'd65535, 16'h5535, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
        tbl[4] = '{16'd7,     16'h0007, 1'b0, {7'h40, 7'h40, 7'h40, 7'h78}};
        tbl[5] = '{16'd8642,  16'h8642, 1'b0, {7'h00, 7'h02, 7'h19, 7'h24}};
        tbl[6] = '{16'd1,     16'h0001, 1'b0, {7'h40, 7'h40, 7'h40, 7'h79}};
        tbl[7] = '{16'd3071,  16'h3071, 1'b0, {7'h30, 7'h40, 7'h78, 7'h79}};

        reset = 1'b1;
        value_a = '0;
        value_b = '0;
        repeat (3) tick();
        check_reset_vals();
        reset = 1'b0;

        // Idle scan with value 0: no conversion, "0.000".
        n = 0;
        last = 4'hF;
        for (int c = 0; c < 24; c++) begin
            tick();
            check("idle_busy", 32'(busy_a), 32'h0);
            if (an_a != last && n < 8) begin
                seq[n] = an_a;
                n++;
            end
            last = an_a;
        end
        check("scan_count", 32'(n >= 4), 32'h1);
        if (n >= 4) begin
            check("scan0", 32'(seq[0]), 32'hE);
            check("scan1", 32'(seq[1]), 32'hD);
            check("scan2", 32'(seq[2]), 32'hB);
            check("scan3", 32'(seq[3]), 32'h7);
        end
        for (int i = 0; i < 4; i++)
            check_digit(0, i, 7'h40, (i == 3) ? 1'b0 : 1'b1);

        // Latency: 0 -> 532.
        value_a = 16'd532;
        for (int k = 1; k <= 18; k++) begin
            tick();
            check($sformatf("lat_busy_t%0d", k), 32'(busy_a),
                  32'(k <= 17));
            if (k == 17)
                check("lat_bcd_t17", 32'(bcd_a), 32'h0);
            if (k == 18) begin
                check("lat_bcd_t18", 32'(bcd_a), 32'h0532);
                check("lat_ovf_t18", 32'(ovf_a), 32'h0);
            end
        end
        check_digit(0, 2, 7'h12, 1'b1);

        // Table of values.
        for (int v = 0; v < 8; v++) begin
            value_a = tbl[v].value;
            repeat (20) tick();
            check($sformatf("tbl%0d_bcd", v), 32'(bcd_a), 32'(tbl[v].bcd));
            check($sformatf("tbl%0d_ovf", v), 32'(ovf_a), 32'(tbl[v].ovf));
            for (int i = 0; i < 4; i++)
                check_digit(0, i, tbl[v].seg[i],
                            (i == 3 && !tbl[v].ovf) ? 1'b0 : 1'b1);
        end

        // No decimal point: blank down to the tens digit.
        value_b = 16'd7;
        repeat (20) tick();
        check("b_bcd", 32'(bcd_b), 32'h0007);
        for (int i = 0; i < 4; i++)
            check_digit(1, i, (i == 0) ? 7'h78 : 7'h7F, 1'b1);

        // Value change during conversion is picked up afterwards.
        value_a = 16'd100;
        for (int k = 1; k <= 37; k++) begin
            tick();
            if (k == 5)
                value_a = 16'd200;
            if (k == 18)
                check("retrig_bcd_t18", 32'(bcd_a), 32'h0100);
            if (k == 19)
                check("retrig_busy_t19", 32'(busy_a), 32'h1);
            if (k == 37)
                check("retrig_bcd_t37", 32'(bcd_a), 32'h0200);
        end

        // Reset mid-conversion, then reconvert the held value.
        value_a = 16'd900;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 3)
                check("mid_busy", 32'(busy_a), 32'h1);
        end
        reset = 1'b1;
        tick();
        check_reset_vals();
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 1)
                check("rel_busy", 32'(busy_a), 32'h1);
            if (k == 17)
                check("rel_bcd_t17", 32'(bcd_a), 32'h0);
            if (k == 18)
                check("rel_bcd_t18", 32'(bcd_a), 32'h0900);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mv_display_driver.md
# mv_display_driver

Downstream display stage for the scaled ADC path. It takes the 16-bit millivolt value and converts it to BCD with a sequential double-dabble converter. It latches the digits atomically and drives a 4-digit, time-multiplexed, active-low seven-segment display, so a Basys-class board shows the reading as volts, for example "0.532".

## Interface
Parameters:
- CLK_HZ, 100_000_000, clk frequency
- DIGIT_HZ, 1000, per-digit dwell rate; DIV = CLK_HZ/DIGIT_HZ clocks per digit (must be ≥ 2)
- DP_DIGIT, 3, digit position lit with the decimal point (0 = units, 4 = none)
- BLANK_LEADING, 1, blank leading zeros on digits above DP_DIGIT

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- value  in  16  unsigned millivolt value (scaled ADC output)
- an  out  4  anodes, active-low one-hot; an[0] = units digit
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g
- dp  out  1  decimal point, active-low
- bcd  out  16  latched BCD digits {thousands, hundreds, tens, units}
- overflow  out  1  latched value > 9999
- busy  out  1  conversion in progress

## Operation
- Converter FSM states:
  - IDLE: if value != last_cap, capture value into the shift register and last_cap, clear the BCD accumulator, and go to SHIFT.
  - SHIFT: 16 cycles. Each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd20, bin} left by 1. After the 16th shift, go to DONE.
  - DONE: one cycle. Load bcd from the low 4 nibbles and set overflow = (ten-thousands nibble != 0). Go to IDLE.
- busy = 1 in SHIFT and DONE.
- Changes to value during SHIFT or DONE are ignored. Because IDLE compares value against last_cap, a changed value retriggers on return to IDLE. No sample is lost as long as value settles.
- Accumulator is 20 bits (5 nibbles). Max input 65535 converts exactly.
- Scan: a DIV-cycle prescaler advances a 2-bit digit index 0→1→2→3→0, wrapping.
- an, seg and dp are registered from the same index and update on the same edge.
- Digit rendering, applied in this order:
  - overflow = 1: all digits show dash (seg 7'h3F), dp off.
  - Otherwise, leading-zero blanking: if BLANK_LEADING, blank a digit at position > DP_DIGIT when it and all higher digits are 0. Blanked digits output seg 7'h7F. Blanking never applies at or below DP_DIGIT, and the units digit is never blanked.
  - Otherwise, digit shows its glyph (0 = 7'h40, 5 = 7'h12, etc.).
  - dp = 0 only when index == DP_DIGIT and overflow = 0.

## Timing
- Reset values: an=4'hF, seg=7'h7F, dp=1, bcd=0, overflow=0, busy=0, last_cap=0, FSM=IDLE, prescaler=0, index=0.
- Within DIV cycles after reset the scan drives digit 0. With the defaults the display shows "0.000".
- Latency: value presented at edge t is captured at edge t+1 (IDLE) if it differs from last_cap. bcd and overflow update at edge t+18. The display reflects the new value from the next scan slot.
- bcd and overflow change only in DONE, so there is no tearing mid-frame.
- Reset mid-conversion aborts immediately to reset values. A conversion starts after reset only once value != 0.

## Structure
- Shared package display_pkg holds:
  - typedef bcd_digit_t (logic [3:0])
  - seg constants SEG_BLANK, SEG_DASH
  - function seg_decode(bcd_digit_t) returning the active-low glyph for 0–9
  - converter state enum
- Sub-module bin2bcd_seq (16-bit in, 20-bit BCD out, start/busy/done) contains the FSM.
- The top level keeps the change detector, the latch, the prescaler/scan and the rendering.

## Test plan
- Reset, value=0, DIV=4 -> no conversion, busy stays 0. One full scan shows an cycling E,D,B,7 with seg 40,40,40,40 and dp=0 only on an=7.
- value 0→532 -> busy high edges t+1..t+17, bcd=16'h0532 at t+18, overflow=0. Scan digit2 shows seg 7'h12.
- value=12345 -> overflow=1, bcd=16'h2345, every digit seg 7'h3F, dp never 0.
- DP_DIGIT=4, BLANK_LEADING=1, value=7 -> digits 3..1 seg 7'h7F, digit0 seg 7'h78, dp always 1.
- value changes 100→200 at t+5 of a conversion -> bcd=0x0100 at t+18, then recapture. bcd=0x0200 at t+37.
- Assert reset at t+8 of a conversion -> next-cycle outputs equal reset values, bcd stays 0. Release with value held at 900 -> new conversion, bcd=0x0900 after 18 cycles.
